// File: rtl/sort_result_reader.sv
// sort_result_reader
//   Captures a run of n words from a sorter output stream into an internal
//   buffer. While capturing it checks that the words arrive in non-descending
//   order and records the index of the first word that breaks that order.
//   The buffer can be read back through a registered read port at any time.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   start      : one-cycle request to begin a capture (accepted in IDLE/DONE)
//   n          : number of words to capture, sampled with an accepted start
//   in_valid   : sorter output word present
//   in_data    : sorter output word
//   in_ready   : reader accepts a word this cycle (CAPTURE only)
//   rd_addr    : readback index into the capture buffer
//   rd_data    : buffer[rd_addr], registered (one cycle latency)
//   busy       : capture in progress
//   done       : capture complete (level)
//   order_err  : sticky, a descending pair was seen in this run
//   err_index  : index of the first word smaller than its predecessor
//   count      : words captured so far in the current run
module sort_result_reader #(
    parameter int DATAWIDTH = 8,
    parameter int MAXCOUNT  = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8:0]           n,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic [8:0]           rd_addr,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 order_err,
    output logic [8:0]           err_index,
    output logic [8:0]           count
);

    localparam int AW = $clog2(MAXCOUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 order_err_q;
    logic [8:0]           err_index_q;
    logic [8:0]           count_q;
    logic [8:0]           n_q;
    logic [DATAWIDTH-1:0] prev_q;
    logic [DATAWIDTH-1:0] rd_data_q;
    logic [DATAWIDTH-1:0] mem_q [MAXCOUNT];

    logic beat_d;
    logic start_ok_d;

    // in_ready_q is high exactly in CAPTURE, so a beat can only occur there.
    assign beat_d     = in_valid && in_ready_q;
    assign start_ok_d = start && (state_q != CAPTURE);

    // Control FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            order_err_q <= 1'b0;
            err_index_q <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        count_q     <= '0;
                        order_err_q <= 1'b0;
                        err_index_q <= '0;
                        if (n != 9'd0) begin
                            state_q    <= CAPTURE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end else begin
                            // Empty run completes immediately.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (beat_d) begin
                        count_q <= count_q + 9'd1;
                        // Only the first descending pair is recorded.
                        if ((count_q != 9'd0) && (in_data < prev_q) && !order_err_q) begin
                            order_err_q <= 1'b1;
                            err_index_q <= count_q;
                        end
                        if (count_q + 9'd1 == n_q) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Run length and previous word are plain data; they need no reset.
    always_ff @(posedge clk) begin
        if (start_ok_d) begin
            n_q <= n;
        end
        if (beat_d) begin
            prev_q <= in_data;
        end
    end

    // Capture buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (beat_d) begin
            mem_q[AW'(count_q)] <= in_data;
        end
    end

    // Registered readback. On a same-address read/write the old word is
    // returned because the array update lands after this read samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[AW'(rd_addr)];
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign order_err = order_err_q;
    assign err_index = err_index_q;
    assign count     = count_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sort_result_reader.sv
// Testbench for sort_result_reader: directed scenarios plus randomized runs,
// with a scoreboard of expected run results and readback words.
module tb_sort_result_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8:0]    n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [8:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          order_err;
    logic [8:0]    err_index;
    logic [8:0]    count;

    always #5 clk = ~clk;

    sort_result_reader #(.DATAWIDTH(DW), .MAXCOUNT(512)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .order_err (order_err),
        .err_index (err_index),
        .count     (count)
    );

    typedef struct packed {
        logic [8:0] cnt;
        logic       oe;
        logic [8:0] ei;
    } run_t;

    run_t          run_q[$];
    logic [DW-1:0] rdexp_q[$];
    logic [DW-1:0] mm [512];   // reference image of the capture buffer
    logic          rd_issue = 1'b0;
    logic          rd_pend  = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result of a run: straight from the ordering rule.
    function automatic run_t model(input int nv, input logic [DW-1:0] w[$]);
        run_t r;
        r.cnt = nv[8:0];
        r.oe  = 1'b0;
        r.ei  = '0;
        for (int i = 1; i < nv; i++) begin
            if (!r.oe && (w[i] < w[i-1])) begin
                r.oe = 1'b1;
                r.ei = i[8:0];
            end
        end
        return r;
    endfunction

    always @(posedge clk) rd_pend <= rd_issue;

    // Monitor: pops an expected run when done is presented, and an expected
    // word one cycle after each issued read.
    always @(negedge clk) begin
        run_t          e;
        logic [DW-1:0] r;
        if (done && (run_q.size() > 0)) begin
            e = run_q.pop_front();
            chk("run_count", count, e.cnt);
            chk("run_order_err", order_err, e.oe);
            chk("run_err_index", err_index, e.ei);
        end
        if (rd_pend) begin
            if (rdexp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_underflow got %0d expected none", rd_data);
            end else begin
                r = rdexp_q.pop_front();
                chk("rd_data", rd_data, r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nv);
        start = 1'b1;
        n     = nv[8:0];
        tick();
        start = 1'b0;
    endtask

    task automatic readback(input int addr);
        rd_addr  = addr[8:0];
        rd_issue = 1'b1;
        rdexp_q.push_back(mm[addr]);
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_order_err"}, order_err, 0);
        chk({tag, "_err_index"}, err_index, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Full capture run. Gaps per beat are drawn from [gmin,gmax]; coll_idx
    // issues a same-address read on that beat; restart_at injects a start
    // with n=1 before that beat.
    task automatic run(input int nv, input logic [DW-1:0] w[$], input int gmin, input int gmax,
                       input int coll_idx, input int restart_at);
        int g;
        do_start(nv);
        run_q.push_back(model(nv, w));
        for (int i = 0; i < nv; i++) begin
            if (i == restart_at) begin
                start = 1'b1;
                n     = 9'd1;
                tick();
                start = 1'b0;
            end
            g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
            for (int k = 0; k < g; k++) begin
                chk("in_ready_gap", in_ready, 1);
                tick();
            end
            chk("in_ready_beat", in_ready, 1);
            chk("no_early_done", done, 0);
            in_valid = 1'b1;
            in_data  = w[i];
            if (i == coll_idx) begin
                rd_addr  = i[8:0];
                rd_issue = 1'b1;
                rdexp_q.push_back(mm[i]);
            end
            mm[i] = w[i];
            tick();
            in_valid = 1'b0;
            rd_issue = 1'b0;
        end
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
        chk("in_ready_after_last", in_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w[$];
        int            nv;
        int            v;

        rst      = 1'b1;
        start    = 1'b0;
        n        = '0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Ascending run of 33 words, no gaps, then read back index 5.
        w = {};
        for (int i = 0; i < 33; i++) w.push_back(i[DW-1:0]);
        run(33, w, 0, 0, -1, -1);
        chk("asc_count", count, 33);
        readback(5);
        tick();

        // Descending pair with a same-address read on beat 1 (old word 1).
        w = {8'd3, 8'd7, 8'd2, 8'd1};
        run(4, w, 0, 0, 1, -1);
        tick();

        // Equal values with 5-cycle gaps.
        w = {8'd9, 8'd9, 8'd9};
        run(3, w, 5, 5, -1, -1);
        tick();

        // Empty run.
        w = {};
        run(0, w, 0, 0, -1, -1);
        tick();
        chk("n0_in_ready", in_ready, 0);
        chk("n0_done_held", done, 1);

        // Reset in the middle of a capture.
        do_start(10);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(100 + i);
            mm[i]    = 8'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count", count, 4);
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        tick();
        chk("abort_no_done", done, 0);
        readback(2);
        w = {8'd50, 8'd60};
        run(2, w, 0, 1, -1, -1);
        tick();

        // Start with n=1 while capturing is ignored.
        w = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        run(5, w, 0, 0, -1, 2);
        // Words offered in DONE must be ignored.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("done_hold_count", count, 5);
        chk("done_hold_done", done, 1);
        tick();

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            nv = int'($urandom_range(40, 1));
            w  = {};
            v  = int'($urandom_range(60, 0));
            for (int i = 0; i < nv; i++) begin
                if ($urandom_range(1, 0) == 0) begin
                    w.push_back(8'($urandom));
                end else begin
                    v = v + int'($urandom_range(5, 0));
                    if (v > 255) v = 255;
                    w.push_back(v[DW-1:0]);
                end
            end
            run(nv, w, 0, 3, -1, -1);
            for (int k = 0; k < 4; k++) readback(int'($urandom_range(nv - 1, 0)));
            tick();
        end

        repeat (3) tick();
        if ((run_q.size() != 0) || (rdexp_q.size() != 0)) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", run_q.size() + rdexp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
